fifo_level: RTL and testbench
=============================

Name: fifo_level

Overview:
Parametrised synchronous FIFO, successor to the basic register-file FIFO. Adds:
- occupancy count output
- programmable almost-full and almost-empty thresholds
- write-through when full with a simultaneous read
- optional sticky overflow/underflow error flags

Used as the standard buffer between producer and consumer stages in one clock domain.

Parameters:
- B, 8: data word width in bits
- W, 4: address width; depth = 2**W words
- AF_LEVEL, 2**W-2: almost_full asserted when count >= AF_LEVEL; legal range 1..2**W
- AE_LEVEL, 1: almost_empty asserted when count <= AE_LEVEL; legal range 0..2**W-1

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- rd  input  1  read request; pops head word at clock edge
- wr  input  1  write request; pushes w_data at clock edge
- w_data  input  B  write data
- r_data  output  B  head-of-FIFO word; valid while empty=0
- empty  output  1  no words stored
- full  output  1  2**W words stored
- almost_empty  output  1  count <= AE_LEVEL
- almost_full  output  1  count >= AF_LEVEL
- count  output  W+1  words currently stored, 0..2**W
- overflow  output  1  sticky; wr while full without rd (FIFO_ERR_EN only, else tied 0)
- underflow  output  1  sticky; rd while empty (FIFO_ERR_EN only, else tied 0)

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - w_ptr=0, r_ptr=0, count=0
  - empty=1, full=0, almost_empty=1
  - almost_full=0 (or 1 only if AF_LEVEL=0, which is illegal)
  - overflow=0, underflow=0
  - Storage contents not cleared; r_data undefined while empty.
  - Reset overrides rd/wr in the same cycle. Reset mid-stream discards all stored data.
- Read path: r_data = mem[r_ptr], combinational from the registered pointer. First-word-fall-through: a word written at edge N is visible on r_data after edge N.
- Effective enables:
  - wr_ok = wr & (~full | rd)
  - rd_ok = rd & ~empty
- Per-edge update, by {wr_ok, rd_ok}:
  - 00: hold.
  - 10: mem[w_ptr]<=w_data; w_ptr+1; count+1.
  - 01: r_ptr+1; count-1.
  - 11: write and read; both pointers +1; count unchanged.
    - When full: the write lands in the slot being freed, so full stays 1.
    - When empty, rd_ok=0 and this case cannot occur; the write proceeds alone.
- Empty with rd=1 and wr=1: write only, and the word appears on r_data next cycle. No same-cycle bypass.
- Pointers are W bits and wrap modulo 2**W naturally. count is W+1 bits so it distinguishes 0 from 2**W.
- Flags, all registered and updated in the same edge as count:
  - empty = (count==0)
  - full = (count==2**W)
  - almost_empty = (count<=AE_LEVEL)
  - almost_full = (count>=AF_LEVEL)
- Dropped requests change no state:
  - wr while full with rd=0
  - rd while empty

Optional Feature:
Macro FIFO_ERR_EN.
- Defined:
  - overflow set on any edge with wr=1, full=1, rd=0.
  - underflow set on any edge with rd=1, empty=1.
  - Both are sticky until reset.
- Undefined: overflow and underflow are constant 0 and no error registers are synthesised.
- Data path behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg:
  - function for depth (2**W)
  - count-width constant helper (W+1)
  - op encoding constants for {wr_ok, rd_ok}: OP_NONE, OP_RD, OP_WR, OP_RW
- Sub-module fifo_ram:
  - B x 2**W register file
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
- fifo_level holds the pointers, count, flag and error logic.

Test Plan (B=8, W=4, AF_LEVEL=14, AE_LEVEL=1):
- Reset, then idle: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Write 0x01..0x10 back-to-back: count=16, full=1 after edge 16, almost_full=1 from count=14, almost_empty=0 from count=2. Then read 16 times: r_data sequence 0x01..0x10, empty=1 at end.
- Full FIFO, rd=1 and wr=1 with w_data=0xAA for 20 cycles: count stays 16, full stays 1, output order preserved across pointer wrap, overflow stays 0.
- Empty FIFO, rd=1 and wr=1 with w_data=0x55: after the edge count=1, r_data=0x55, underflow=1 (FIFO_ERR_EN build).
- Full FIFO, wr=1 with rd=0 and w_data=0xEE: count stays 16, 0xEE never appears on r_data, overflow=1 and stays 1 until reset.
- Count=9 mid-stream, assert reset for one cycle with wr=1: count=0, empty=1, flags cleared. A following write of 0x33 gives r_data=0x33.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and op encoding for the level FIFO
package fifo_pkg;

   function automatic int depth(input int w);
      return 1 << w;
   endfunction

   function automatic int cnt_w(input int w);
      return w + 1;
   endfunction

   // Encoded as {wr_ok, rd_ok}
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RW   = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - B x 2**W register file, sync write port, async read port
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int B = 8,
   parameter int W = 4
)(
   input  logic         clk,
   input  logic         we,
   input  logic [W-1:0] waddr,
   input  logic [B-1:0] wdata,
   input  logic [W-1:0] raddr,
   output logic [B-1:0] rdata
);

   logic [B-1:0] mem [depth(W)];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - synchronous FIFO with count, thresholds, write-through; FIFO_ERR_EN adds sticky error flags
module fifo_level
   import fifo_pkg::*;
#(
   parameter int B        = 8,
   parameter int W        = 4,
   parameter int AF_LEVEL = 2**W - 2,
   parameter int AE_LEVEL = 1
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         rd,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow
);

   localparam int CW = cnt_w(W);
   localparam logic [CW-1:0] FULL_C = CW'(depth(W));
   localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

   logic           wr_ok;
   logic           rd_ok;
   fifo_op_e       op;
   logic [W-1:0]   w_ptr;
   logic [W-1:0]   r_ptr;
   logic [W-1:0]   w_ptr_nxt;
   logic [W-1:0]   r_ptr_nxt;
   logic [CW-1:0]  count_nxt;

   always_comb begin
      wr_ok     = wr & (~full | rd);
      rd_ok     = rd & ~empty;
      op        = fifo_op_e'({wr_ok, rd_ok});
      w_ptr_nxt = w_ptr;
      r_ptr_nxt = r_ptr;
      count_nxt = count;
      case (op)
         OP_WR: begin
            w_ptr_nxt = w_ptr + W'(1);
            count_nxt = count + CW'(1);
         end
         OP_RD: begin
            r_ptr_nxt = r_ptr + W'(1);
            count_nxt = count - CW'(1);
         end
         OP_RW: begin
            w_ptr_nxt = w_ptr + W'(1);
            r_ptr_nxt = r_ptr + W'(1);
         end
         default: ;
      endcase
      if (reset) begin
         w_ptr_nxt = '0;
         r_ptr_nxt = '0;
         count_nxt = '0;
      end
   end

   // Flags are registered from the next count so they move in the same edge as count
   always_ff @(posedge clk) begin
      w_ptr        <= w_ptr_nxt;
      r_ptr        <= r_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == FULL_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
   end

   fifo_ram #(.B(B), .W(W)) u_ram (
      .clk   (clk),
      .we    (wr_ok & ~reset),
      .waddr (w_ptr),
      .wdata (w_data),
      .raddr (r_ptr),
      .rdata (r_data)
   );

`ifdef FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr & full & ~rd)
            overflow <= 1'b1;
         if (rd & empty)
            underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - randomized self-checking bench for fifo_level against a queue model
module tb_fifo_level;

   localparam int B     = 8;
   localparam int W     = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 1;

`ifdef FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rd = 1'b0;
   logic         wr = 1'b0;
   logic [B-1:0] w_data = '0;
   logic [B-1:0] r_data;
   logic         empty, full, almost_empty, almost_full, overflow, underflow;
   logic [W:0]   count;

   int errors = 0;
   int checks = 0;

   logic [B-1:0] q[$];
   bit           m_ovf = 1'b0;
   bit           m_unf = 1'b0;

   fifo_level #(.B(B), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk          (clk),
      .reset        (reset),
      .rd           (rd),
      .wr           (wr),
      .w_data       (w_data),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the model applies the FIFO rules to its queue at the edge
   task automatic step(input logic r, input logic w, input logic [B-1:0] d, input logic rst);
      bit was_full, was_empty;
      rd = r; wr = w; w_data = d; reset = rst;
      @(posedge clk);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (ERR_EN && w && was_full && !r) m_ovf = 1'b1;
         if (ERR_EN && r && was_empty)      m_unf = 1'b1;
         if (r && !was_empty)               void'(q.pop_front());
         if (w && (!was_full || r))         q.push_back(d);
      end
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset;
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow);
      end
   endtask

   task automatic test_fill_drain;
      for (int i = 1; i <= DEPTH; i++) begin
         step(0, 1, 8'(i), 0);
         checks++;
         if (count !== 5'(i) || full !== (i == DEPTH) || almost_full !== (i >= AF) ||
             almost_empty !== (i <= AE) || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags i=%0d got cnt=%0d f=%b af=%b ae=%b e=%b", i, count, full,
                     almost_full, almost_empty, empty);
         end
      end
      for (int i = 1; i <= DEPTH; i++) begin
         checks++;
         if (r_data !== 8'(i)) begin errors++; $display("FAIL drain_data got=%h exp=%h", r_data, 8'(i)); end
         step(1, 0, 8'h00, 0);
      end
      checks++; if (empty !== 1'b1 || count !== 5'd0) begin
         errors++; $display("FAIL drain_empty got e=%b cnt=%0d exp e=1 cnt=0", empty, count);
      end
   endtask

   task automatic test_full_rw;
      while (q.size() < DEPTH) step(0, 1, 8'($urandom), 0);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (r_data !== q[0]) begin errors++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, r_data, q[0]); end
         step(1, 1, 8'hAA, 0);
         checks++;
         if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL wrap_state i=%0d got cnt=%0d f=%b ovf=%b exp 16 1 0", i, count, full, overflow);
         end
      end
   endtask

   task automatic test_empty_rw;
      while (q.size() > 0) step(1, 0, 8'h00, 0);
      step(1, 1, 8'h55, 0);
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL erw_count got=%0d exp=1", count); end
      checks++; if (r_data !== 8'h55) begin errors++; $display("FAIL erw_data got=%h exp=55", r_data); end
      checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL erw_unf got=%b exp=%b", underflow, ERR_EN); end
   endtask

   task automatic test_overflow;
      while (q.size() < DEPTH) step(0, 1, 8'($urandom_range(0, 8'hED)), 0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'hEE, 0);
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
      checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ERR_EN); end
      while (q.size() > 0) begin
         checks++;
         if (r_data === 8'hEE || r_data !== q[0]) begin
            errors++; $display("FAIL ovf_data got=%h exp=%h", r_data, q[0]);
         end
         step(1, 0, 8'h00, 0);
      end
      checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", overflow, ERR_EN); end
   endtask

   task automatic test_reset_mid;
      while (q.size() < 9) step(0, 1, 8'($urandom), 0);
      checks++; if (count !== 5'd9) begin errors++; $display("FAIL mid_pre got=%0d exp=9", count); end
      step(0, 1, 8'h77, 1);
      checks++;
      if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
          almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got cnt=%0d e=%b ae=%b f=%b af=%b ovf=%b unf=%b", count, empty,
                  almost_empty, full, almost_full, overflow, underflow);
      end
      step(0, 1, 8'h33, 0);
      checks++; if (r_data !== 8'h33 || count !== 5'd1) begin
         errors++; $display("FAIL mid_write got=%h cnt=%0d exp=33 cnt=1", r_data, count);
      end
   endtask

   // Phases bias writes high or low so the run repeatedly reaches both full and empty
   task automatic test_random;
      int wp;
      for (int i = 0; i < 600; i++) begin
         wp = ((i / 50) % 2 == 0) ? 80 : 20;
         step(1'($urandom_range(0, 99) >= wp), 1'($urandom_range(0, 99) < wp), 8'($urandom), 0);
         checks++;
         if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
             almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE) ||
             overflow !== m_ovf || underflow !== m_unf || (q.size() > 0 && r_data !== q[0])) begin
            errors++;
            $display("FAIL rand i=%0d got cnt=%0d d=%h e=%b f=%b af=%b ae=%b o=%b u=%b exp cnt=%0d d=%h o=%b u=%b",
                     i, count, r_data, empty, full, almost_full, almost_empty, overflow, underflow,
                     q.size(), (q.size() > 0) ? q[0] : 8'h00, m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fill_drain();
      test_full_rw();
      test_empty_rw();
      test_overflow();
      test_reset_mid();
      step(0, 0, 8'h00, 1);
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
